chan_mux_arb: RTL
=================

# chan_mux_arb

Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready handshaking, generalising the five-input 1-bit select mux to multi-bit channels, any channel count, and two selection modes: fixed select and round-robin arbitration. It sits between multiple producer channels and a single downstream consumer. Out-of-range selects are flagged rather than driving X.

## Interface
- N_CH, 5, number of input channels (2..16)
- WIDTH, 8, data bits per channel
- SEL_W, 3, select/channel-index width; must satisfy 2**SEL_W >= N_CH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel data valid
- in_ready  output  N_CH  per-channel accept; combinational
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index in fixed mode
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  consumer accepts when high with out_valid
- out_ch  output  SEL_W  index of channel that supplied out_data
- sel_err  output  1  registered one-cycle pulse: fixed-mode sel >= N_CH

## Operation
- Output register "free" when !out_valid || out_ready.
- Grant (combinational, one-hot or zero):
  - Fixed mode: grant[sel] = in_valid[sel] when sel < N_CH; else no grant.
  - Round-robin: first i with in_valid[i], searching from rr_ptr+1 upward modulo N_CH.
- in_ready[i] = grant[i] && free. Transfer on channel i when in_valid[i] && in_ready[i].
- On transfer: out_data <= channel data, out_ch <= i, out_valid <= 1; round-robin mode also sets rr_ptr <= i.
- Free with no transfer: out_valid <= 0; out_data and out_ch hold their last values.
- Not free (out_valid && !out_ready): output registers hold; no in_ready asserted.
- rr_ptr changes only on a round-robin transfer; fixed-mode transfers leave it unchanged.
- sel_err <= (mode == 0) && (sel >= N_CH), every cycle, independent of in_valid and free.
- mode or sel may change any cycle; takes effect on the same cycle's grant.

## Timing
- Reset values (asynchronous): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=N_CH-1 (so channel 0 has first priority).
- Latency: input accepted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous drain and fill: when out_valid && out_ready, a new word may load on the same edge.
- Reset mid-transfer: a word held in the output register is discarded; no in_ready is asserted while rst_n=0.
- Wrap-around: rr_ptr = N_CH-1 searches from channel 0; N_CH not a power of two wraps at N_CH, never at 2**SEL_W.

## Configuration
- CHMUX_ROUND_ROBIN_EN defined: both modes present as above.
- Undefined: the mode input is ignored and treated as 0, rr_ptr logic is removed, and fixed-select behaviour and sel_err are unchanged.

## Test plan
- Reset: assert rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, sel_err=0, in_ready=0.
- Fixed mode, N_CH=5: sel=3, in_valid=5'b01000, ch3 data=8'hA5, out_ready=1 -> in_ready=5'b01000; next cycle out_data=8'hA5, out_ch=3, out_valid=1.
- Fixed out-of-range: sel=6 with all in_valid=1 -> in_ready=0, sel_err=1 one cycle later, out_valid drops to 0.
- Round-robin: all in_valid=1, out_ready=1 for 7 cycles -> out_ch sequence 0,1,2,3,4,0,1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0; on out_ready=1, drain and reload on the same edge.
- Mid-operation reset: reset while out_valid=1 in round-robin after out_ch=2 -> out_valid=0; first post-reset grant is channel 0.

Source files
------------

// File: rtl/chan_mux_arb_if.sv
// Producer/consumer bundle for chan_mux_arb: N_CH input channels, one registered
// output channel, plus the select controls and the out-of-range select flag.
`timescale 1ns/1ps
interface chan_mux_arb_if #(
    parameter int N_CH  = 5,
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_ch;
    logic                  sel_err;

    // Environment side: drives producers, consumer ready and selection.
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, sel_err
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, sel_err
    );
endinterface

// File: rtl/chan_mux_arb.sv
// N-channel W-bit mux with registered valid/ready output, fixed-select and
// round-robin modes. Round-robin is built only when CHMUX_ROUND_ROBIN_EN is defined.
`timescale 1ns/1ps
module chan_mux_arb #(
    parameter int N_CH  = 5,
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_mux_arb_if.slave  bus
);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [N_CH-1:0]  fix_grant;
    logic [N_CH-1:0]  grant;
    logic [N_CH-1:0]  in_ready;
    logic             mode_eff;
    logic             free;
    logic             xfer;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic             sel_err_q,   sel_err_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign ch_data[gi]   = bus.in_data[gi*WIDTH +: WIDTH];
            // Channels only exist below N_CH, so an out-of-range sel grants nothing.
            assign fix_grant[gi] = (int'(bus.sel) == gi) && bus.in_valid[gi];
        end
    endgenerate

`ifdef CHMUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]  rr_grant;

    assign mode_eff = bus.mode;

    // Search starts just after the last winner and wraps at N_CH, not 2**SEL_W.
    always_comb begin
        int  idx;
        logic found;
        rr_grant = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_CH;
            if (!found && bus.in_valid[idx]) begin
                rr_grant[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign grant    = mode_eff ? rr_grant : fix_grant;
    assign rr_ptr_d = (xfer && mode_eff) ? grant_idx : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= SEL_W'(N_CH - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = bus.mode;
    assign mode_eff    = 1'b0;
    assign grant       = fix_grant;
`endif

    assign free     = !out_valid_q || bus.out_ready;
    // Gating with rst_n keeps every ready low while reset is held.
    assign in_ready = grant & {N_CH{free & rst_n}};
    assign xfer     = |in_ready;

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = ch_data[i];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (free) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_data;
                out_ch_d   = grant_idx;
            end
        end
        sel_err_d = !mode_eff && (int'(bus.sel) >= N_CH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule
